ts_stage_fifo: RTL
==================

# ts_stage_fifo

Parametrised elastic stage for the market-data pipeline, succeeding the fixed single-entry stage registers between eth_rx, parser, trading_logic and uart_tx. It buffers up to DEPTH words under a valid/ready handshake and tags each word with the free-running cycle counter at ingress. On egress it reports the ingress timestamp and the residence latency. It also counts downstream stall cycles, so latency and back-pressure can be measured at any stage boundary.

## Interface
- DATA_W, 32, payload width in bits
- DEPTH, 4, number of entries; must be a power of two, ≥2
- TS_W, 32, timestamp and latency width
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cycle_cnt  in  TS_W  free-running cycle counter shared by the pipeline
- flush  in  1  synchronous clear of stored entries
- in_data  in  DATA_W  upstream payload
- in_valid  in  1  upstream word present
- in_ready  out  1  stage can accept a word
- out_data  out  DATA_W  head-of-queue payload
- out_valid  out  1  head entry present
- out_ready  in  1  downstream accepts the head entry
- out_ts  out  TS_W  cycle_cnt sampled when the head entry was pushed
- out_lat  out  TS_W  cycle_cnt − out_ts, modulo 2^TS_W
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- stall_cycles  out  32  count of cycles with out_valid=1 and out_ready=0
- max_lat  out  TS_W  largest out_lat seen at a pop (see Configuration)

## Operation
- Storage: DEPTH-entry circular buffer of {data, ts}. Read pointer, write pointer and count are registered. Pointers are $clog2(DEPTH) bits and wrap naturally.
- push = in_valid & in_ready. On push, the entry at the write pointer captures in_data and the current cycle_cnt.
- pop = out_valid & out_ready. On pop, the read pointer advances.
- in_ready = (count != DEPTH). It is combinational from count only and never depends on out_ready. A full FIFO does not accept a word in the same cycle a pop occurs.
- out_valid = (count != 0). out_data and out_ts are the entry at the read pointer (first-word fall-through).
- out_lat is combinational: cycle_cnt − out_ts, truncated to TS_W bits. Wrap of cycle_cnt yields the correct modular difference.
- count update: +1 on push only, −1 on pop only, unchanged on push and pop together or on neither.
- stall_cycles increments on every cycle with out_valid & ~out_ready. It saturates at 0xFFFF_FFFF. flush does not clear it.
- flush: at the next edge, count and both pointers go to 0. flush has priority over push and pop in the same cycle; that push is discarded and that pop is not counted. in_ready stays combinational, so upstream must hold off during flush.
- level = count.

## Timing
- Reset values: count 0, pointers 0, all storage 0, out_valid 0, out_data 0, out_ts 0, level 0, stall_cycles 0, max_lat 0. in_ready is 1 while in reset.
- Reset is asserted asynchronously. It may hit mid-transfer; all entries are lost and no partial state survives.
- Latency: a word pushed at edge N appears on out_data with out_valid=1 after edge N. The minimum out_lat seen at its pop is therefore 1.
- Empty: no bypass. A word cannot be pushed and popped in the same cycle.
- Throughput: one push and one pop per cycle when 0 < count < DEPTH. Full throughput needs DEPTH ≥ 2.
- out_data, out_ts and out_valid are stable while out_valid=1 and out_ready=0.

## Configuration
- TS_STAGE_FIFO_MAXLAT_EN defined: a max_lat register is included. On each pop where out_lat > max_lat, it loads out_lat. It is cleared only by rst_n.
- Undefined: max_lat is tied to 0 and no comparator or register is built.

## Test plan
- Single word: DEPTH=4, push 0xDEADBEEF at cycle_cnt=100, out_ready=1. Required: out_valid rises after that edge; at pop, out_ts=100 and out_lat=1; level returns to 0.
- Fill and back-pressure: out_ready=0, push 5 words. Required: in_ready=0 after the 4th push; 5th word not accepted; level=4; stall_cycles increments by 1 per cycle while out_valid=1.
- Steady stream: push and pop every cycle for 1000 words. Required: in-order data, level constant at 1, all out_lat=1, stall_cycles unchanged.
- Timestamp wrap: cycle_cnt=0xFFFF_FFFE at push, pop 3 cycles later. Required: out_lat=3.
- Flush: flush with 3 entries stored and push asserted in the same cycle. Required: next cycle level=0, out_valid=0, stall_cycles preserved.
- Max latency (macro defined): pop words with latencies 1, 7, 3. Required: max_lat=7. Macro undefined: max_lat=0.

Source files
------------

// File: rtl/ts_stage_fifo.sv
// ts_stage_fifo: elastic valid/ready stage that timestamps each word at ingress
// and reports its ingress timestamp and residence latency at egress. It also
// counts downstream stall cycles.
// Optional feature macro: TS_STAGE_FIFO_MAXLAT_EN adds a max-latency register
// (max_lat); without it max_lat is tied to zero.
module ts_stage_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TS_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [TS_W-1:0]           cycle_cnt,
    input  logic                      flush,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TS_W-1:0]           out_ts,
    output logic [TS_W-1:0]           out_lat,
    output logic [$clog2(DEPTH):0]    level,
    output logic [31:0]               stall_cycles,
    output logic [TS_W-1:0]           max_lat
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [TS_W-1:0]   r_ts   [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [31:0]       r_stall;

    logic w_push;
    logic w_pop;
    logic w_lat_unused;

    // Handshake and head-of-queue views; in_ready depends on count only.
    assign in_ready     = (r_count != FULL_CNT);
    assign out_valid    = (r_count != '0);
    assign out_data     = r_data[r_rd_ptr];
    assign out_ts       = r_ts[r_rd_ptr];
    assign out_lat      = cycle_cnt - r_ts[r_rd_ptr];
    assign level        = r_count;
    assign stall_cycles = r_stall;
    assign w_lat_unused = 1'b0;

    // flush overrides both transfers in the same cycle.
    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    // Occupancy next-state: simultaneous push and pop leave count unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Entry storage: payload plus ingress timestamp, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_ts[i]   <= '0;
            end
        end else if (w_push) begin
            r_data[r_wr_ptr] <= in_data;
            r_ts[r_wr_ptr]   <= cycle_cnt;
        end
    end

    // Saturating count of cycles where the head is held by downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (out_valid && !out_ready && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

`ifdef TS_STAGE_FIFO_MAXLAT_EN
    logic [TS_W-1:0] r_max_lat;

    // Track the largest latency observed at a pop; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_lat <= '0;
        end else if (w_pop && (out_lat > r_max_lat)) begin
            r_max_lat <= out_lat;
        end
    end

    assign max_lat = r_max_lat;
`else
    assign max_lat = '0;
`endif

endmodule
